// File: rtl/flag_pkg.sv
// rtl/flag_pkg.sv - opcode, condition-code and state types plus the flag write mask.
package flag_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NE  = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GE  = 3'b100,
    CC_LE  = 3'b101,
    CC_OV  = 3'b110,
    CC_UNC = 3'b111
  } ccc_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int Z_IDX = 2;
  localparam int V_IDX = 1;
  localparam int N_IDX = 0;

  // Which flag bits an opcode writes; opcodes 1xxx fall to the default.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB: begin
        m[Z_IDX] = 1'b1;
        m[V_IDX] = 1'b1;
        m[N_IDX] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[Z_IDX] = 1'b1;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch condition evaluator over Z/V/N flags.
module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[Z_IDX];
  assign v = flags[V_IDX];
  assign n = flags[N_IDX];

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | ~n;
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - architectural flag register and branch resolve/stall control.
// Optional FLAG_FWD_EN: dependent branches use forwarded flags instead of stalling.
module flag_unit
  import flag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       EX_valid,
  input  logic [3:0] EX_Opcode,
  input  logic [2:0] ALU_Flags,
  input  logic       Flush,
  input  logic       Br_valid,
  input  logic [2:0] Br_ccc,
  output logic [2:0] Flags,
  output logic       Br_ready,
  output logic       Br_taken
);

  logic [2:0] flags_q, flags_d;
  state_e     state_q, state_d;
  logic [2:0] wr_mask;
  logic       ex_wr;
  logic       dependent;
  logic       stall;
  logic [2:0] eval_flags;
  logic       cond_taken;

  assign wr_mask   = flag_mask(EX_Opcode);
  assign ex_wr     = EX_valid & ~Flush;
  assign dependent = ex_wr & (|wr_mask);
  assign flags_d   = ex_wr ? ((flags_q & ~wr_mask) | (ALU_Flags & wr_mask)) : flags_q;
  assign Flags     = flags_q;

`ifdef FLAG_FWD_EN
  assign eval_flags = dependent ? flags_d : flags_q;
  assign stall      = 1'b0;
`else
  assign eval_flags = flags_q;
  assign stall      = Br_valid & dependent;
`endif

  cond_eval u_cond_eval (
    .ccc   (Br_ccc),
    .flags (eval_flags),
    .taken (cond_taken)
  );

  always_comb begin
    state_d  = state_q;
    Br_ready = 1'b1;
    Br_taken = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stall) begin
          state_d  = S_WAIT;
          Br_ready = 1'b0;
        end else begin
          Br_taken = Br_valid & cond_taken;
        end
      end
      // Flags were written at the edge entering WAIT; never re-stall here.
      S_WAIT: begin
        state_d  = S_IDLE;
        Br_taken = Br_valid & cond_taken;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      state_d  = S_IDLE;
      Br_ready = 1'b1;
      Br_taken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
      state_q <= S_IDLE;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed self-checking bench for flag_unit (default build).
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       EX_valid;
  logic [3:0] EX_Opcode;
  logic [2:0] ALU_Flags;
  logic       Flush;
  logic       Br_valid;
  logic [2:0] Br_ccc;
  logic [2:0] Flags;
  logic       Br_ready;
  logic       Br_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_unit dut (
    .clk       (clk),
    .rst       (rst),
    .EX_valid  (EX_valid),
    .EX_Opcode (EX_Opcode),
    .ALU_Flags (ALU_Flags),
    .Flush     (Flush),
    .Br_valid  (Br_valid),
    .Br_ccc    (Br_ccc),
    .Flags     (Flags),
    .Br_ready  (Br_ready),
    .Br_taken  (Br_taken)
  );

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [3:0] op, input logic [2:0] alu,
                       input logic fl, input logic bv, input logic [2:0] cc);
    EX_valid  = ev;
    EX_Opcode = op;
    ALU_Flags = alu;
    Flush     = fl;
    Br_valid  = bv;
    Br_ccc    = cc;
    #2;
  endtask

  function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b1, 4'b0000, 3'b111, 1'b0, 1'b1, 3'b111);
    tick;
    drive(1'b1, 4'b0000, 3'b111, 1'b0, 1'b1, 3'b111);
    chk3("rst_flags", Flags, 3'b000);
    chk1("rst_ready", Br_ready, 1'b1);
    chk1("rst_taken", Br_taken, 1'b0);
    tick;
    rst = 1'b0;

    // Reset state, EQ branch with Z=0
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 3'b001);
    chk3("init_flags", Flags, 3'b000);
    chk1("init_ready", Br_ready, 1'b1);
    chk1("init_taken", Br_taken, 1'b0);

    // Dependent branch stalls one cycle, then resolves on fresh flags
    drive(1'b1, 4'b0000, 3'b100, 1'b0, 1'b1, 3'b001);
    chk1("haz_ready0", Br_ready, 1'b0);
    chk1("haz_taken0", Br_taken, 1'b0);
    tick;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 3'b001);
    chk1("wait_ready", Br_ready, 1'b1);
    chk1("wait_taken", Br_taken, 1'b1);
    chk3("wait_flags", Flags, 3'b100);
    tick;

    // Flag write during WAIT does not re-stall; branch uses registered flags
    drive(1'b1, 4'b0001, 3'b010, 1'b0, 1'b1, 3'b110);
    chk1("haz2_ready0", Br_ready, 1'b0);
    tick;
    drive(1'b1, 4'b0000, 3'b001, 1'b0, 1'b1, 3'b110);
    chk1("nore_ready", Br_ready, 1'b1);
    chk1("nore_taken", Br_taken, 1'b1);
    tick;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 3'b011);
    chk3("nore_flags", Flags, 3'b001);
    chk1("after_ready", Br_ready, 1'b1);
    chk1("after_lt", Br_taken, 1'b1);

    // WAIT with Br_valid dropped returns quietly to IDLE
    drive(1'b1, 4'b0010, 3'b000, 1'b0, 1'b1, 3'b000);
    chk1("haz3_ready0", Br_ready, 1'b0);
    tick;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000);
    chk1("drop_ready", Br_ready, 1'b1);
    chk1("drop_taken", Br_taken, 1'b0);
    tick;
    drive(1'b1, 4'b0010, 3'b100, 1'b0, 1'b1, 3'b000);
    chk1("idle_again_ready0", Br_ready, 1'b0);
    tick;

    // Update masks
    drive(1'b1, 4'b0001, 3'b011, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("sub_flags", Flags, 3'b011);
    drive(1'b1, 4'b0010, 3'b100, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("xor_flags", Flags, 3'b111);
    drive(1'b1, 4'b0011, 3'b000, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("red_flags", Flags, 3'b111);
    drive(1'b1, 4'b0100, 3'b011, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("sll_flags", Flags, 3'b011);
    drive(1'b1, 4'b0111, 3'b100, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("paddsb_flags", Flags, 3'b011);
    drive(1'b1, 4'b1000, 3'b100, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("op1xxx_flags", Flags, 3'b011);
    drive(1'b1, 4'b0110, 3'b100, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("ror_flags", Flags, 3'b111);
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("novalid_flags", Flags, 3'b111);

    // Flush: no write, no stall
    drive(1'b1, 4'b0000, 3'b000, 1'b0, 1'b0, 3'b000);
    tick;
    chk3("clear_flags", Flags, 3'b000);
    drive(1'b1, 4'b0001, 3'b011, 1'b1, 1'b1, 3'b110);
    chk1("flush_ready", Br_ready, 1'b1);
    chk1("flush_taken", Br_taken, 1'b0);
    tick;
    chk3("flush_flags", Flags, 3'b000);

    // No branch: ready high, taken low even with a flag writer in EX
    drive(1'b1, 4'b0000, 3'b101, 1'b0, 1'b0, 3'b111);
    chk1("nobr_ready", Br_ready, 1'b1);
    chk1("nobr_taken", Br_taken, 1'b0);
    tick;
    chk3("nobr_flags", Flags, 3'b101);

    // Sweep every condition over every flag value
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 4'b0000, 3'(f), 1'b0, 1'b0, 3'b000);
      tick;
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 3'(c));
        chk1($sformatf("sweep_rdy_f%0d_c%0d", f, c), Br_ready, 1'b1);
        chk1($sformatf("sweep_tk_f%0d_c%0d", f, c), Br_taken, exp_taken(3'(c), 3'(f)));
      end
    end
    tick;

    // Reset during WAIT abandons the branch and blocks that cycle's write
    drive(1'b1, 4'b0000, 3'b100, 1'b0, 1'b1, 3'b000);
    chk1("prerst_ready0", Br_ready, 1'b0);
    tick;
    chk3("prerst_flags", Flags, 3'b100);
    rst = 1'b1;
    drive(1'b1, 4'b0000, 3'b011, 1'b0, 1'b1, 3'b111);
    chk1("rstwait_ready", Br_ready, 1'b1);
    chk1("rstwait_taken", Br_taken, 1'b0);
    tick;
    rst = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 3'b001);
    chk3("postrst_flags", Flags, 3'b000);
    chk1("postrst_ready", Br_ready, 1'b1);
    chk1("postrst_taken", Br_taken, 1'b0);
    drive(1'b1, 4'b0000, 3'b100, 1'b0, 1'b1, 3'b001);
    chk1("postrst_idle_stall", Br_ready, 1'b0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
